nn_result_reader: RTL
=====================

Name: nn_result_reader

Overview:
- Host-side controller for the NN accelerator top. Each command produces one start_flag pulse to the accelerator. The block then waits for end_flag and captures the two classifier scores.
- It then reads a programmable window of the shared activation RAM through the testbench/host read port. The bytes go out as a valid/ready byte stream with credit-based flow control.
- It sits between the system host (or the bench) and the accelerator top, replacing direct testbench pokes of ram_en_rtb/ram_addr_rtb.

Parameters:
- ADDR_W, 16: RAM address width; matches ram_addr_rtb.
- DATA_W, 8: RAM data width; matches ram_data_r.
- RD_LAT, 1: cycles from ram_en_rtb high to valid ram_data_r; legal 1..3.
- FIFO_DEPTH, 4: output skid FIFO entries; must be >= RD_LAT+2 (elaboration assert).
- TIMEOUT_CYC, 2000000: watchdog limit in cycles; used only with NN_TIMEOUT_EN.

Ports:
- sys_clk, in, 1: sole clock.
- rst_n, in, 1: reset; asynchronous assert, active-low.
- cmd_valid, in, 1: host requests a run.
- cmd_ready, out, 1: high only in IDLE.
- cmd_base, in, ADDR_W: first RAM address to read back.
- cmd_len, in, ADDR_W: number of bytes to read back; 0 is legal.
- start_flag, out, 1: one-cycle start pulse to the accelerator.
- end_flag, in, 1: completion indication from the accelerator.
- NN_out_male, in, 8: signed male score.
- NN_out_female, in, 8: signed female score.
- ram_en_rtb, out, 1: RAM read enable.
- ram_addr_rtb, out, ADDR_W: RAM read address.
- ram_data_r, in, DATA_W: RAM read data.
- out_valid, out, 1: stream byte valid.
- out_ready, in, 1: stream consumer ready.
- out_data, out, DATA_W: stream byte.
- out_last, out, 1: marks the final byte of a run.
- score_male, out, 8: captured male score.
- score_female, out, 8: captured female score.
- is_male, out, 1: classification result.
- busy, out, 1: high whenever the state is not IDLE.
- done, out, 1: one-cycle pulse at end of run.
- err_timeout, out, 1: sticky timeout flag.

Behaviour:
- Reset values: all outputs 0 except cmd_ready=1. FIFO empty, state IDLE.
- Reset mid-run: everything clears immediately. No start_flag pulse or stream beat is produced after reset releases until a new command.
- IDLE:
  - On cmd_valid&&cmd_ready, latch cmd_base and cmd_len into rd_addr/rd_rem.
  - Go to START. cmd_ready drops the following cycle.
- START:
  - start_flag=1 for exactly one cycle.
  - Go to WAIT_END.
- WAIT_END:
  - end_flag is edge-detected with a register end_d. Advance only on end_flag&&!end_d, so a stale high level from a prior run is ignored.
  - On that edge, capture NN_out_male/NN_out_female into score_male/score_female.
  - is_male = ($signed(male) > $signed(female)); a tie gives 0.
  - Go to READ if rd_rem != 0, else go to DONE.
- READ, issue rule:
  - Issue a read when rd_rem != 0 && (inflight + fifo_count) < FIFO_DEPTH.
  - An issue sets ram_en_rtb=1 and ram_addr_rtb=rd_addr, then rd_addr++ and rd_rem--.
  - ram_en_rtb is 0 in every other state and cycle.
- READ, data return:
  - Track returns with an RD_LAT-deep valid shift register. inflight = popcount of that register.
  - The returning byte is pushed into the FIFO. The credit rule guarantees it never overflows.
  - rd_addr wraps from 2^ADDR_W-1 to 0 with no error.
- READ exit: go to DRAIN when rd_rem == 0 and inflight == 0.
- DRAIN: go to DONE when the FIFO is empty and no beat is pending.
- DONE: done=1 for one cycle, then go to IDLE.
- Output stream:
  - out_data/out_valid come from the FIFO head. A pop happens on out_valid&&out_ready.
  - out_data is stable while out_valid&&!out_ready.
  - out_last=1 on the cmd_len-th byte only.
  - Simultaneous push and pop is allowed when full, and fifo_count is unchanged.
- Throughput: with out_ready held high, one byte per cycle after an initial RD_LAT+1 cycle latency.
- cmd_valid outside IDLE is ignored (cmd_ready=0).

Optional Feature:
- Macro: NN_TIMEOUT_EN.
- Defined:
  - A 32-bit counter runs in WAIT_END.
  - If it reaches TIMEOUT_CYC, set err_timeout (sticky until the next accepted command), skip READ, and go to DONE.
  - Scores are not updated.
- Undefined:
  - No counter; WAIT_END waits indefinitely.
  - err_timeout is tied to 0.

Decomposition:
- Shared package nn_host_pkg holds the state enum (IDLE, START, WAIT_END, READ, DRAIN, DONE) and default ADDR_W/DATA_W constants.
- One sub-module: nn_sync_fifo, a parameterised DEPTH/WIDTH synchronous FIFO with count output, instantiated for the stream buffer.

Test Plan:
- Basic run:
  - cmd_base=0x0100, cmd_len=4, RAM preloaded 0x11..0x14, end_flag pulses 50 cycles after start_flag, out_ready=1.
  - Expect one start_flag pulse; bytes 11,12,13,14 with out_last on 14; done one cycle after the last byte is accepted.
- Backpressure:
  - cmd_len=16, out_ready toggles at random.
  - Expect all 16 bytes in order with no loss or duplication, and FIFO count never above FIFO_DEPTH.
  - Check RD_LAT=1 and RD_LAT=3 builds.
- Scores:
  - NN_out_male=0xF0 (-16), NN_out_female=0x05 → is_male=0.
  - Male=0x40, female=0x40 → is_male=0.
  - Male=0x10, female=0x80 → is_male=1.
- Edge cases:
  - cmd_len=0: start_flag pulses, end_flag edge arrives, no ram_en_rtb ever, done asserts.
  - cmd_base=0xFFFE, len=3: addresses FFFE, FFFF, 0000.
  - end_flag held high from reset: no advance until a fresh rising edge.
- Reset mid-READ:
  - Assert rst_n=0 after the 2nd of 8 bytes.
  - All outputs return to reset values immediately; a new command completes normally.
- NN_TIMEOUT_EN, TIMEOUT_CYC=100:
  - end_flag never asserts → err_timeout=1 at cycle 100 of WAIT_END, done pulse, no RAM reads.
  - The next command clears err_timeout.

Source files
------------

// File: rtl/nn_host_pkg.sv
// Shared types and defaults for the NN accelerator host-side result reader.
// The state encoding and the score-compare helper are used by the top and the bench.
package nn_host_pkg;

   localparam int NN_ADDR_W = 16;
   localparam int NN_DATA_W = 8;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_START    = 3'd1,
      ST_WAIT_END = 3'd2,
      ST_READ     = 3'd3,
      ST_DRAIN    = 3'd4,
      ST_DONE     = 3'd5
   } nn_state_e;

   // Ties resolve to female.
   function automatic logic score_is_male(input logic [7:0] male, input logic [7:0] female);
      return $signed(male) > $signed(female);
   endfunction

endpackage

// File: rtl/nn_sync_fifo.sv
// Parameterised synchronous FIFO with first-word-fall-through head and an occupancy count.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module nn_sync_fifo #(
   parameter int  DEPTH = 4,
   parameter int  WIDTH = 8,
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_en,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop_en,
   output logic [WIDTH-1:0] head_data,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push, do_pop;

   assign do_pop  = pop_en && (count_q != '0);
   assign do_push = push_en && ((count_q != CNT_W'(DEPTH)) || do_pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) begin
         wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
         rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage carries no reset; the count alone decides what is valid.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= push_data;
      end
   end

   assign head_data = mem_q[rd_ptr_q];
   assign empty     = (count_q == '0);
   assign count     = count_q;

endmodule

// File: rtl/nn_result_reader.sv
// Host controller: starts the NN accelerator, captures its scores, then streams a RAM window out.
// Define NN_TIMEOUT_EN to add a WAIT_END watchdog that drives err_timeout.
module nn_result_reader
   import nn_host_pkg::*;
#(
   parameter int ADDR_W      = NN_ADDR_W,
   parameter int DATA_W      = NN_DATA_W,
   parameter int RD_LAT      = 1,
   parameter int FIFO_DEPTH  = 4,
   parameter int TIMEOUT_CYC = 2000000
) (
   input  logic              sys_clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [ADDR_W-1:0] cmd_base,
   input  logic [ADDR_W-1:0] cmd_len,
   output logic              start_flag,
   input  logic              end_flag,
   input  logic [7:0]        NN_out_male,
   input  logic [7:0]        NN_out_female,
   output logic              ram_en_rtb,
   output logic [ADDR_W-1:0] ram_addr_rtb,
   input  logic [DATA_W-1:0] ram_data_r,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   output logic [7:0]        score_male,
   output logic [7:0]        score_female,
   output logic              is_male,
   output logic              busy,
   output logic              done,
   output logic              err_timeout
);

   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int FW    = DATA_W + 1;

   generate
      if (RD_LAT < 1 || RD_LAT > 3 || FIFO_DEPTH < RD_LAT + 2 || TIMEOUT_CYC < 1) begin : g_bad_cfg
         $error("nn_result_reader: illegal RD_LAT/FIFO_DEPTH/TIMEOUT_CYC combination");
      end
   endgenerate

   nn_state_e         state_q, state_d;
   logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
   logic [ADDR_W-1:0] rd_rem_q, rd_rem_d;
   logic              end_d_q;
   logic [7:0]        score_male_q, score_male_d;
   logic [7:0]        score_female_q, score_female_d;
   logic              is_male_q, is_male_d;
   logic [RD_LAT-1:0] vld_sr_q, vld_sr_d;
   logic [RD_LAT-1:0] last_sr_q, last_sr_d;
`ifdef NN_TIMEOUT_EN
   logic [31:0]       tmo_cnt_q, tmo_cnt_d;
   logic              err_q, err_d;
`endif

   logic [CNT_W-1:0]  fifo_count;
   logic              fifo_empty;
   logic [FW-1:0]     fifo_head;
   logic [7:0]        inflight;
   logic              issue, push, pop, drained, end_edge;

   always_comb begin
      inflight = '0;
      for (int i = 0; i < RD_LAT; i++) begin
         inflight = inflight + 8'(vld_sr_q[i]);
      end
   end

   // Credits count both queued bytes and reads still in the RAM pipeline, so pushes never overflow.
   assign issue    = (state_q == ST_READ) && (rd_rem_q != '0) &&
                     ((inflight + 8'(fifo_count)) < 8'(FIFO_DEPTH));
   assign push     = vld_sr_q[RD_LAT-1];
   assign pop      = !fifo_empty && out_ready;
   assign drained  = (fifo_count == '0) || ((fifo_count == CNT_W'(1)) && pop);
   assign end_edge = end_flag && !end_d_q;

   assign vld_sr_d  = (vld_sr_q << 1) | RD_LAT'(issue);
   assign last_sr_d = (last_sr_q << 1) | RD_LAT'(issue && (rd_rem_q == ADDR_W'(1)));

   nn_sync_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (FW)
   ) u_fifo (
      .clk       (sys_clk),
      .rst_n     (rst_n),
      .push_en   (push),
      .push_data ({last_sr_q[RD_LAT-1], ram_data_r}),
      .pop_en    (pop),
      .head_data (fifo_head),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   always_comb begin
      state_d        = state_q;
      rd_addr_d      = rd_addr_q;
      rd_rem_d       = rd_rem_q;
      score_male_d   = score_male_q;
      score_female_d = score_female_q;
      is_male_d      = is_male_q;
`ifdef NN_TIMEOUT_EN
      tmo_cnt_d      = '0;
      err_d          = err_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               rd_addr_d = cmd_base;
               rd_rem_d  = cmd_len;
`ifdef NN_TIMEOUT_EN
               err_d     = 1'b0;
`endif
               state_d   = ST_START;
            end
         end
         ST_START: state_d = ST_WAIT_END;
         ST_WAIT_END: begin
            if (end_edge) begin
               score_male_d   = NN_out_male;
               score_female_d = NN_out_female;
               is_male_d      = score_is_male(NN_out_male, NN_out_female);
               state_d        = (rd_rem_q != '0) ? ST_READ : ST_DONE;
            end
`ifdef NN_TIMEOUT_EN
            else if (tmo_cnt_q == 32'(TIMEOUT_CYC - 1)) begin
               err_d   = 1'b1;
               state_d = ST_DONE;
            end else begin
               tmo_cnt_d = tmo_cnt_q + 32'd1;
            end
`endif
         end
         ST_READ: begin
            if (issue) begin
               rd_addr_d = rd_addr_q + ADDR_W'(1);
               rd_rem_d  = rd_rem_q - ADDR_W'(1);
            end
            // Skipping DRAIN when the last byte leaves now puts done right after its acceptance.
            if (rd_rem_q == '0 && inflight == '0) begin
               state_d = drained ? ST_DONE : ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (drained) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= ST_IDLE;
         rd_addr_q      <= '0;
         rd_rem_q       <= '0;
         end_d_q        <= 1'b0;
         score_male_q   <= '0;
         score_female_q <= '0;
         is_male_q      <= 1'b0;
         vld_sr_q       <= '0;
         last_sr_q      <= '0;
`ifdef NN_TIMEOUT_EN
         tmo_cnt_q      <= '0;
         err_q          <= 1'b0;
`endif
      end else begin
         state_q        <= state_d;
         rd_addr_q      <= rd_addr_d;
         rd_rem_q       <= rd_rem_d;
         end_d_q        <= end_flag;
         score_male_q   <= score_male_d;
         score_female_q <= score_female_d;
         is_male_q      <= is_male_d;
         vld_sr_q       <= vld_sr_d;
         last_sr_q      <= last_sr_d;
`ifdef NN_TIMEOUT_EN
         tmo_cnt_q      <= tmo_cnt_d;
         err_q          <= err_d;
`endif
      end
   end

   assign cmd_ready    = (state_q == ST_IDLE);
   assign busy         = (state_q != ST_IDLE);
   assign start_flag   = (state_q == ST_START);
   assign done         = (state_q == ST_DONE);
   assign ram_en_rtb   = issue;
   assign ram_addr_rtb = rd_addr_q;
   assign out_valid    = !fifo_empty;
   assign out_data     = fifo_empty ? '0 : fifo_head[DATA_W-1:0];
   assign out_last     = !fifo_empty && fifo_head[DATA_W];
   assign score_male   = score_male_q;
   assign score_female = score_female_q;
   assign is_male      = is_male_q;
`ifdef NN_TIMEOUT_EN
   assign err_timeout  = err_q;
`else
   assign err_timeout  = 1'b0;
`endif

endmodule
